// File: rtl/qpsk_pkg.sv
// Shared widths, bit positions and types for the QPSK hard-decision symbol packer.
package qpsk_pkg;

  localparam int unsigned QPSK_IQ_WIDTH      = 16;
  localparam int unsigned QPSK_SYMS_PER_WORD = 16;
  localparam int unsigned QPSK_DATA_W        = 2 * QPSK_IQ_WIDTH;
  localparam int unsigned QPSK_I_MSB         = QPSK_DATA_W - 1;
  localparam int unsigned QPSK_Q_MSB         = QPSK_IQ_WIDTH - 1;
  localparam int unsigned QPSK_IDX_W         = $clog2(QPSK_SYMS_PER_WORD);
  localparam int unsigned QPSK_TUSER_W       = QPSK_IDX_W + 1;

  typedef logic [1:0] qpsk_sym_t;

  typedef struct packed {
    logic [QPSK_DATA_W-1:0]  data;
    logic [QPSK_TUSER_W-1:0] user;
    logic                    last;
  } qpsk_word_t;

  // Position a 2-bit symbol at bits [2*idx+1:2*idx] of an otherwise-zero word.
  function automatic logic [QPSK_DATA_W-1:0] place_sym(input qpsk_sym_t sym,
                                                       input logic [QPSK_IDX_W-1:0] idx);
    return QPSK_DATA_W'(sym) << {idx, 1'b0};
  endfunction

endpackage

// File: rtl/qpsk_hard_slicer.sv
// Combinational Gray-QPSK sign slicer: {b1,b0} = {sign(I), sign(Q)}, zero slices to 0.
module qpsk_hard_slicer
  import qpsk_pkg::*;
#(
  parameter int unsigned I_MSB = QPSK_I_MSB,
  parameter int unsigned Q_MSB = QPSK_Q_MSB
) (
  input  logic [QPSK_DATA_W-1:0] i_iq,
  output qpsk_sym_t              o_sym
);

  // Only the two sign bits carry the decision; the magnitudes are don't-care.
  logic w_unused_mag;

  assign o_sym        = {i_iq[I_MSB], i_iq[Q_MSB]};
  assign w_unused_mag = ^i_iq;

endmodule

// File: rtl/qpsk_symbol_packer.sv
// Packs sliced QPSK symbols LSB-first into 32-bit words; a word closes on 16 symbols or TLAST.
module qpsk_symbol_packer
  import qpsk_pkg::*;
#(
  parameter int unsigned IQ_WIDTH      = QPSK_IQ_WIDTH,
  parameter int unsigned SYMS_PER_WORD = QPSK_SYMS_PER_WORD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [QPSK_DATA_W-1:0]  i_data_TDATA,
  input  logic                    i_data_TLAST,
  input  logic                    i_data_TVALID,
  output logic                    i_data_TREADY,
  output logic [QPSK_DATA_W-1:0]  o_data_TDATA,
  output logic [QPSK_TUSER_W-1:0] o_data_TUSER,
  output logic                    o_data_TLAST,
  output logic                    o_data_TVALID,
  input  logic                    o_data_TREADY
);

  logic [QPSK_DATA_W-1:0]  r_acc;
  logic [QPSK_IDX_W-1:0]   r_idx;
  qpsk_word_t              r_out;
  logic                    r_out_valid;

  qpsk_sym_t               w_sym;
  logic                    w_accept;
  logic                    w_full;
  logic                    w_done;
  logic [QPSK_DATA_W-1:0]  w_acc_next;
  logic [QPSK_TUSER_W-1:0] w_user;

  qpsk_hard_slicer #(
    .I_MSB(2 * IQ_WIDTH - 1),
    .Q_MSB(IQ_WIDTH - 1)
  ) u_slicer (
    .i_iq  (i_data_TDATA),
    .o_sym (w_sym)
  );

  assign i_data_TREADY = !r_out_valid || o_data_TREADY;
  assign w_accept      = i_data_TVALID && i_data_TREADY;
  assign w_full        = (r_idx == QPSK_IDX_W'(SYMS_PER_WORD - 1));
  assign w_done        = w_accept && (w_full || i_data_TLAST);
  assign w_acc_next    = r_acc | place_sym(w_sym, r_idx);
  assign w_user        = {1'b0, r_idx} + QPSK_TUSER_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_idx       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_done) begin
          r_acc <= '0;
          r_idx <= '0;
        end else begin
          r_acc <= w_acc_next;
          r_idx <= r_idx + QPSK_IDX_W'(1);
        end
      end
      // Acceptance implies the output slot is free or draining this cycle, so a
      // completing word can always overwrite it without loss.
      if (w_done) begin
        r_out.data  <= w_acc_next;
        r_out.user  <= w_user;
        r_out.last  <= i_data_TLAST;
        r_out_valid <= 1'b1;
      end else if (o_data_TREADY) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_data_TDATA  = r_out.data;
  assign o_data_TUSER  = r_out.user;
  assign o_data_TLAST  = r_out.last;
  assign o_data_TVALID = r_out_valid;

endmodule

// File: tb/tb_qpsk_symbol_packer.sv
// Directed and randomly throttled checks of qpsk_symbol_packer against hand values and a packing model.
`timescale 1ns/1ps
module tb_qpsk_symbol_packer;

  localparam logic [31:0] IQ_PP = 32'h0064_0064;  // (+100,+100)
  localparam logic [31:0] IQ_PN = 32'h0064_FF9C;  // (+100,-100)
  localparam logic [31:0] IQ_NP = 32'hFF9C_0064;  // (-100,+100)
  localparam logic [31:0] IQ_NN = 32'hFF9C_FF9C;  // (-100,-100)
  localparam logic [31:0] IQ_ZZ = 32'h0000_0000;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  u;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_data_TDATA;
  logic        i_data_TLAST;
  logic        i_data_TVALID;
  logic        i_data_TREADY;
  logic [31:0] o_data_TDATA;
  logic [4:0]  o_data_TUSER;
  logic        o_data_TLAST;
  logic        o_data_TVALID;
  logic        o_data_TREADY;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  word_t       obs_q[$];
  word_t       exp_q[$];
  int unsigned m_cnt  = 0;
  logic [31:0] m_word = '0;
  logic        rand_done;

  qpsk_symbol_packer #(
    .IQ_WIDTH      (16),
    .SYMS_PER_WORD (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_data_TDATA  (i_data_TDATA),
    .i_data_TLAST  (i_data_TLAST),
    .i_data_TVALID (i_data_TVALID),
    .i_data_TREADY (i_data_TREADY),
    .o_data_TDATA  (o_data_TDATA),
    .o_data_TUSER  (o_data_TUSER),
    .o_data_TLAST  (o_data_TLAST),
    .o_data_TVALID (o_data_TVALID),
    .o_data_TREADY (o_data_TREADY)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Output monitor and reference packer, both sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      m_cnt  = 0;
      m_word = '0;
    end else begin
      if (o_data_TVALID && o_data_TREADY)
        obs_q.push_back('{d: o_data_TDATA, u: o_data_TUSER, l: o_data_TLAST});
      if (i_data_TVALID && i_data_TREADY) begin
        m_word[2*m_cnt +: 2] = {i_data_TDATA[31], i_data_TDATA[15]};
        m_cnt = m_cnt + 1;
        if (m_cnt == 16 || i_data_TLAST) begin
          exp_q.push_back('{d: m_word, u: 5'(m_cnt), l: i_data_TLAST});
          m_cnt  = 0;
          m_word = '0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int unsigned n;
    n = 0;
    i_data_TDATA  = d;
    i_data_TLAST  = l;
    i_data_TVALID = 1'b1;
    @(negedge clk);
    while (!i_data_TREADY && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!i_data_TREADY) check("send_timeout", {31'b0, i_data_TREADY}, 32'd1);
    @(posedge clk);
    #1;
    i_data_TVALID = 1'b0;
    i_data_TLAST  = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic flush();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_word(input string tag, input int unsigned idx,
                            input logic [31:0] d, input logic [4:0] u, input logic l);
    if (idx < obs_q.size()) begin
      check({tag, "_data"}, obs_q[idx].d, d);
      check({tag, "_user"}, {27'b0, obs_q[idx].u}, {27'b0, u});
      check({tag, "_last"}, {31'b0, obs_q[idx].l}, {31'b0, l});
    end else begin
      check({tag, "_count"}, obs_q.size(), idx + 1);
    end
  endtask

  task automatic compare_queues(input string tag);
    int unsigned n;
    check({tag, "_nwords"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++)
      check_word(tag, i, exp_q[i].d, exp_q[i].u, exp_q[i].l);
    flush();
  endtask

  initial begin
    rst           = 1'b0;
    i_data_TDATA  = '0;
    i_data_TLAST  = 1'b0;
    i_data_TVALID = 1'b0;
    o_data_TREADY = 1'b1;
    rand_done     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tvalid", {31'b0, o_data_TVALID}, 32'd0);
    check("rst_tdata",  o_data_TDATA, 32'd0);
    check("rst_tuser",  {27'b0, o_data_TUSER}, 32'd0);
    check("rst_tlast",  {31'b0, o_data_TLAST}, 32'd0);
    check("rst_tready", {31'b0, i_data_TREADY}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 16 x (+,-) with TLAST on the 16th
    for (int unsigned k = 0; k < 16; k++) begin
      send_beat(IQ_PN, k == 15);
      if (k == 14) check("t16_pre_valid", {31'b0, o_data_TVALID}, 32'd0);
    end
    check("t16_latency", {31'b0, o_data_TVALID}, 32'd1);
    drain();
    check("t16_count", obs_q.size(), 32'd1);
    check_word("t16", 0, 32'h5555_5555, 5'd16, 1'b1);
    flush();

    // 5-symbol constellation walk
    send_beat(IQ_PP, 1'b0);
    send_beat(IQ_PN, 1'b0);
    send_beat(IQ_NP, 1'b0);
    send_beat(IQ_NN, 1'b0);
    send_beat(IQ_ZZ, 1'b1);
    drain();
    check("t5_count", obs_q.size(), 32'd1);
    check_word("t5", 0, 32'h0000_00E4, 5'd5, 1'b1);
    flush();

    // 20 x (-,-): full word then a 4-symbol tail
    for (int unsigned k = 0; k < 20; k++) send_beat(IQ_NN, k == 19);
    drain();
    check("t20_count", obs_q.size(), 32'd2);
    check_word("t20a", 0, 32'hFFFF_FFFF, 5'd16, 1'b0);
    check_word("t20b", 1, 32'h0000_00FF, 5'd4, 1'b1);
    flush();

    // Backpressure: downstream stalls for 10 cycles after the first word
    o_data_TREADY = 1'b0;
    fork
      begin
        for (int unsigned k = 0; k < 20; k++) send_beat($urandom, k == 19);
      end
      begin
        int unsigned n;
        int unsigned good;
        logic [31:0] held_d;
        logic [4:0]  held_u;
        n    = 0;
        good = 0;
        @(negedge clk);
        while (!o_data_TVALID && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("bp_valid", {31'b0, o_data_TVALID}, 32'd1);
        check("bp_tready_low", {31'b0, i_data_TREADY}, 32'd0);
        held_d = o_data_TDATA;
        held_u = o_data_TUSER;
        repeat (10) begin
          @(negedge clk);
          if (o_data_TDATA === held_d && o_data_TUSER === held_u &&
              o_data_TVALID === 1'b1 && i_data_TREADY === 1'b0)
            good++;
        end
        check("bp_hold", good, 32'd10);
        @(posedge clk);
        #1;
        o_data_TREADY = 1'b1;
      end
    join
    drain();
    check("bp_count", obs_q.size(), 32'd2);
    compare_queues("bp");

    // Reset mid-packet discards the partial word
    for (int unsigned k = 0; k < 7; k++) send_beat(IQ_NN, 1'b0);
    check("rstmid_noout", obs_q.size(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_tready", {31'b0, i_data_TREADY}, 32'd1);
    check("rstmid_tvalid", {31'b0, o_data_TVALID}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    flush();
    for (int unsigned k = 0; k < 3; k++) send_beat(IQ_PN, k == 2);
    drain();
    check("rstmid_count", obs_q.size(), 32'd1);
    check_word("rstmid", 0, 32'h0000_0015, 5'd3, 1'b1);
    flush();

    // Reset drops a pending, unaccepted word
    o_data_TREADY = 1'b0;
    for (int unsigned k = 0; k < 5; k++) send_beat(IQ_NP, k == 4);
    @(negedge clk);
    check("pend_valid", {31'b0, o_data_TVALID}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("pend_rst_tdata", o_data_TDATA, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    o_data_TREADY = 1'b1;
    flush();
    drain();
    check("pend_dropped", obs_q.size(), 32'd0);
    check("pend_tvalid", {31'b0, o_data_TVALID}, 32'd0);

    // Random throttling over 10,000 symbols
    fork
      begin
        int unsigned sent;
        int unsigned len;
        sent = 0;
        while (sent < 10000) begin
          len = $urandom_range(1, 40);
          for (int unsigned k = 0; k < len; k++) begin
            while ($urandom_range(0, 3) == 0) begin
              i_data_TVALID = 1'b0;
              i_data_TDATA  = $urandom;
              i_data_TLAST  = 1'($urandom_range(0, 1));
              @(posedge clk);
              #1;
            end
            send_beat($urandom, k == len - 1);
          end
          sent += len;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          o_data_TREADY = ($urandom_range(0, 2) != 0);
        end
        o_data_TREADY = 1'b1;
      end
    join
    drain();
    if (obs_q.size() > 0)
      check("rand_final_last", {31'b0, obs_q[obs_q.size()-1].l}, 32'd1);
    check("rand_nonempty", {31'b0, obs_q.size() > 0}, 32'd1);
    compare_queues("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
